puf_response_reader: RTL and testbench
======================================

PUF_RESPONSE_READER -- requirements
Module: puf_response_reader

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8, number of cycles puf_start is held high per sample round (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 go  input  1  request a full 16-address sweep; sampled only in IDLE.
REQ-005 puf_start  output  1  drives the PUF START input.
REQ-006 puf_addr  output  4  drives the PUF challenge address.
REQ-007 puf_bit  input  1  PUF response bit (OUT[0]); treated as synchronous to clk.
REQ-008 key_byte  output  8  assembled key byte presented to the consumer.
REQ-009 key_valid  output  1  key_byte valid; valid/ready handshake.
REQ-010 key_ready  input  1  consumer accepts key_byte when high with key_valid.
REQ-011 busy  output  1  high from the cycle after go is accepted until done.
REQ-012 done  output  1  one-cycle pulse after the second key byte is accepted.

Function
REQ-013 FSM states: IDLE, DRIVE, GAP, SEND_LO, SEND_HI; IDLE->DRIVE on go=1.
REQ-014 DRIVE: puf_start=1, puf_addr=current address, settle counter counts SETTLE_CYCLES cycles.
REQ-015 In the last DRIVE cycle, sample puf_bit; DRIVE->GAP.
REQ-016 GAP: puf_start=0 for exactly one cycle; one round = SETTLE_CYCLES+1 cycles.
REQ-017 After the last round for an address, store the resolved bit in key[addr]; address increments, 15 wraps to 0, and GAP->SEND_LO instead of DRIVE.
REQ-018 SEND_LO: key_byte=key[7:0], key_valid=1; on key_valid&key_ready -> SEND_HI.
REQ-019 SEND_HI: key_byte=key[15:8], key_valid=1; on handshake -> IDLE, done=1 for that one following cycle.
REQ-020 key_byte and key_valid are held stable while key_ready=0; no timeout.
REQ-021 go is ignored while busy=1; go held high in IDLE after done starts a new sweep.
REQ-022 puf_addr is 0 in IDLE and SEND states; puf_start is 0 outside DRIVE.
REQ-023 key register is cleared at the start of each sweep.

Reset
REQ-024 reset=1 forces, immediately and independent of clk: state IDLE, puf_start=0, puf_addr=0, key=0, key_byte=0, key_valid=0, busy=0, done=0, all counters 0.
REQ-025 Reset mid-sweep or mid-send discards the partial key; the next go restarts from address 0.

Configuration
REQ-026 Macro PUF_READER_MAJORITY_EN defined: three rounds per address, 3-bit vote, resolved bit = majority (>=2 ones); sweep = 48*(SETTLE_CYCLES+1) cycles.
REQ-027 Macro undefined: one round per address, resolved bit = the single sample; sweep = 16*(SETTLE_CYCLES+1) cycles; vote logic absent.

Verification
REQ-028 SETTLE_CYCLES=4, no macro, PUF model bit=addr[0]^addr[3], key_ready=1, go pulse at edge 0 -> puf_start first high cycle 1, key_valid first high cycle 81, bytes 0xAA then 0x55, done pulse after second handshake.
REQ-029 Same model, key_ready=0 for 10 cycles after key_valid rises -> key_valid=1 and key_byte=0xAA stable all 10 cycles; 0x55 follows the first accepting cycle.
REQ-030 Macro defined, model flips the 2nd of every 3 samples -> bytes 0xAA, 0x55; sweep length 240 cycles for SETTLE_CYCLES=4.
REQ-031 reset asserted while puf_addr=5 -> puf_start, busy, key_valid drop to 0 without a clock edge; next go yields a complete sweep starting at address 0 with correct key.
REQ-032 go pulsed while busy at address 9 -> no restart, address sequence and final bytes 0xAA/0x55 unchanged, exactly one done pulse.

Source files
------------

// File: rtl/puf_response_reader.sv
// Sweeps the 16 PUF challenge addresses and hands out the 16-bit key as two bytes.
// Define PUF_READER_MAJORITY_EN for three rounds per address with a majority vote.
module puf_response_reader #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  output logic       puf_start,
  output logic [3:0] puf_addr,
  input  logic       puf_bit,
  output logic [7:0] key_byte,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    GAP,
    SEND_LO,
    SEND_HI
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [3:0]  r_addr;
  logic [15:0] r_key;
  logic        r_done;
  logic        w_last_drive;
  logic        w_last_round;
  logic        w_resolved;

  assign w_last_drive = (r_state == DRIVE) && (r_cnt == LAST_CNT);

`ifdef PUF_READER_MAJORITY_EN
  logic [1:0] r_round;
  logic [2:0] r_vote;

  assign w_last_round = (r_round == 2'd2);
  assign w_resolved   = (r_vote[0] & r_vote[1]) |
                        (r_vote[0] & r_vote[2]) |
                        (r_vote[1] & r_vote[2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_round <= 2'd0;
      r_vote  <= 3'd0;
    end else if (r_state == IDLE) begin
      r_round <= 2'd0;
      r_vote  <= 3'd0;
    end else if (w_last_drive) begin
      r_vote[r_round] <= puf_bit;
    end else if (r_state == GAP) begin
      r_round <= w_last_round ? 2'd0 : r_round + 2'd1;
    end
  end
`else
  logic r_sample;

  assign w_last_round = 1'b1;
  assign w_resolved   = r_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample <= 1'b0;
    end else if (w_last_drive) begin
      r_sample <= puf_bit;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 8'd0;
      r_addr <= 4'd0;
      r_key  <= 16'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == SEND_HI) && key_ready;
      case (r_state)
        IDLE: begin
          r_cnt  <= 8'd0;
          r_addr <= 4'd0;
          if (go) begin
            r_key <= 16'd0;
          end
        end
        DRIVE: begin
          r_cnt <= w_last_drive ? 8'd0 : r_cnt + 8'd1;
        end
        GAP: begin
          if (w_last_round) begin
            r_key[r_addr] <= w_resolved;
            r_addr        <= r_addr + 4'd1;
          end
        end
        default: begin
          r_cnt <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    puf_start = 1'b0;
    puf_addr  = 4'd0;
    key_byte  = 8'd0;
    key_valid = 1'b0;
    busy      = (r_state != IDLE);
    done      = r_done;
    case (r_state)
      IDLE: begin
        if (go) begin
          w_next = DRIVE;
        end
      end
      DRIVE: begin
        puf_start = 1'b1;
        puf_addr  = r_addr;
        if (w_last_drive) begin
          w_next = GAP;
        end
      end
      GAP: begin
        puf_addr = r_addr;
        // Final address of the final round hands over to the byte transfer.
        if (w_last_round && (r_addr == 4'd15)) begin
          w_next = SEND_LO;
        end else begin
          w_next = DRIVE;
        end
      end
      SEND_LO: begin
        key_byte  = r_key[7:0];
        key_valid = 1'b1;
        if (key_ready) begin
          w_next = SEND_HI;
        end
      end
      SEND_HI: begin
        key_byte  = r_key[15:8];
        key_valid = 1'b1;
        if (key_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_puf_response_reader.sv
// Bench for puf_response_reader: directed and random sweeps against a pattern-based PUF model.
// Follows PUF_READER_MAJORITY_EN so the model flips the 2nd of every 3 samples.
module tb_puf_response_reader;

  localparam int S = 4;
`ifdef PUF_READER_MAJORITY_EN
  localparam int ROUNDS = 3;
`else
  localparam int ROUNDS = 1;
`endif
  localparam int SWEEP = 16 * ROUNDS * (S + 1);

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        puf_start;
  logic [3:0]  puf_addr;
  logic        puf_bit;
  logic [7:0]  key_byte;
  logic        key_valid;
  logic        key_ready;
  logic        busy;
  logic        done;
  logic [15:0] pat;
  logic [15:0] model;
  int          falls = 0;
  int          base = 0;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  puf_response_reader #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .puf_start (puf_start),
    .puf_addr  (puf_addr),
    .puf_bit   (puf_bit),
    .key_byte  (key_byte),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  // Each falling puf_start ends one sample round.
  always @(negedge puf_start) falls++;

  always @* begin
    puf_bit = pat[puf_addr];
    if (ROUNDS == 3 && ((falls - base) % 3) == 1) puf_bit = ~puf_bit;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sweep(input logic [15:0] p, input int st_lo,
                       input int st_hi, input int go_addr);
    int n;
    int bad;
    int nd;
    bit pulsed;
    logic       exp_start;
    logic [3:0] exp_addr;
    pat = p;
    base = falls;
    key_ready = (st_lo == 0);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 1;
    bad = 0;
    pulsed = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    while (!key_valid && n <= SWEEP + 20) begin
      exp_start = ((n - 1) % (S + 1)) < S;
      exp_addr = 4'(((n - 1) / (S + 1)) / ROUNDS);
      if (puf_start !== exp_start || puf_addr !== exp_addr || busy !== 1'b1)
        bad++;
      if (go_addr >= 0 && !pulsed && int'(puf_addr) == go_addr) begin
        go = 1'b1;
        pulsed = 1'b1;
      end else begin
        go = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    go = 1'b0;
    check("sweep_seq_errors", bad, 0);
    check("valid_cycle", n, SWEEP + 1);
    bad = 0;
    for (int i = 0; i < st_lo; i++) begin
      if (key_valid !== 1'b1 || key_byte !== p[7:0]) bad++;
      @(posedge clk); #1;
    end
    check("lo_stall_stable", bad, 0);
    key_ready = 1'b1;
    check("lo_valid", 32'(key_valid), 32'd1);
    check("lo_byte", 32'(key_byte), 32'(p[7:0]));
    @(posedge clk); #1;
    key_ready = (st_hi == 0);
    check("hi_valid", 32'(key_valid), 32'd1);
    check("hi_byte", 32'(key_byte), 32'(p[15:8]));
    bad = 0;
    for (int i = 0; i < st_hi; i++) begin
      if (key_valid !== 1'b1 || key_byte !== p[15:8]) bad++;
      @(posedge clk); #1;
    end
    check("hi_stall_stable", bad, 0);
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(key_valid), 32'd0);
    nd = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    check("done_count", nd, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    go = 1'b0;
    key_ready = 1'b0;
    pat = 16'd0;
    for (int a = 0; a < 16; a++) begin
      model[a] = a[0] ^ a[3];
    end
    #12;
    check("rst_start", 32'(puf_start), 32'd0);
    check("rst_addr", 32'(puf_addr), 32'd0);
    check("rst_byte", 32'(key_byte), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_no_go", 32'(busy), 32'd0);

    sweep(model, 0, 0, -1);
    sweep(model, 10, 0, -1);
    sweep(model, 0, 0, 9);

    pat = 16'($urandom());
    base = falls;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0;
    while (puf_addr !== 4'd5 && n < SWEEP) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_addr5", 32'(puf_addr), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("async_start", 32'(puf_start), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_valid", 32'(key_valid), 32'd0);
    check("async_addr", 32'(puf_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    sweep(16'($urandom()), 0, 0, -1);

    for (int k = 0; k < 3; k++) begin
      sweep(16'($urandom()), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 5)), -1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
